dmem_access_ctrl: RTL and testbench

Load/store sequencer directly upstream of the banked data memory. It accepts one byte, halfword or word request at a time from the core and splits it into little-endian byte beats on the memory's byte-wide read port. It assembles and extends read data, then returns a single response. It also rejects misaligned accesses without touching memory.

---
 rtl/dmem_access_ctrl.sv | 166 ++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer for the byte-wide banked data memory.
// Splits byte/halfword/word requests into little-endian byte beats and returns one response.
module dmem_access_ctrl #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_error,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_en,
  output logic              mem_read_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [7:0]        mem_data_out
);

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_BEAT    = 3'd1,
    RD_ISSUE   = 3'd2,
    RD_CAPTURE = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t              state;
  logic                write_q;
  logic [1:0]          size_q;
  logic                signed_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rbuf_q;
  logic [1:0]          beat_q;

  logic                accept;
  logic                misaligned;
  logic                last_beat;
  logic [1:0]          beat_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   rbuf_nxt;
  logic [DATA_W-1:0]   load_result;

  assign accept     = req_valid && req_ready;
  assign misaligned = (req_size == 2'd3) ||
                      ((req_size == 2'd2) && (req_addr[1:0] != 2'b00)) ||
                      ((req_size == 2'd1) && req_addr[0]);
  assign beat_nxt   = beat_q + 2'd1;
  assign addr_nxt   = addr_q + ADDR_W'(beat_nxt);
  assign last_beat  = (beat_q == ((size_q == 2'd2) ? 2'd3 :
                                  (size_q == 2'd1) ? 2'd1 : 2'd0));

  // Assembly register including the byte arriving this cycle, so the
  // final capture can produce the response on the same edge.
  always_comb begin
    rbuf_nxt = rbuf_q;
    rbuf_nxt[BYTE_W*beat_q +: BYTE_W] = mem_data_out;
  end

  always_comb begin
    load_result = rbuf_nxt;
    case (size_q)
      2'd0:    load_result = {{(DATA_W-8){signed_q & rbuf_nxt[7]}}, rbuf_nxt[7:0]};
      2'd1:    load_result = {{(DATA_W-16){signed_q & rbuf_nxt[15]}}, rbuf_nxt[15:0]};
      default: load_result = rbuf_nxt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      req_ready      <= 1'b0;
      resp_valid     <= 1'b0;
      resp_error     <= 1'b0;
      resp_rdata     <= '0;
      mem_en         <= 1'b0;
      mem_read_write <= 1'b0;
      mem_addr       <= '0;
      mem_data_in    <= '0;
      write_q        <= 1'b0;
      size_q         <= 2'd0;
      signed_q       <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rbuf_q         <= '0;
      beat_q         <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            write_q   <= req_write;
            size_q    <= req_size;
            signed_q  <= req_signed;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            rbuf_q    <= '0;
            beat_q    <= 2'd0;
            if (misaligned) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
            end else begin
              state          <= req_write ? WR_BEAT : RD_ISSUE;
              mem_en         <= 1'b1;
              mem_read_write <= req_write;
              mem_addr       <= req_addr;
              mem_data_in    <= req_write ? DATA_W'(req_wdata[7:0]) : '0;
            end
          end
        end
        WR_BEAT: begin
          if (last_beat) begin
            state          <= DONE;
            mem_en         <= 1'b0;
            mem_read_write <= 1'b0;
            mem_addr       <= '0;
            mem_data_in    <= '0;
            resp_valid     <= 1'b1;
          end else begin
            beat_q      <= beat_nxt;
            mem_addr    <= addr_nxt;
            mem_data_in <= DATA_W'(wdata_q[BYTE_W*beat_nxt +: BYTE_W]);
          end
        end
        RD_ISSUE: begin
          state    <= RD_CAPTURE;
          mem_en   <= 1'b0;
          mem_addr <= '0;
        end
        RD_CAPTURE: begin
          rbuf_q <= rbuf_nxt;
          if (last_beat) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_rdata <= load_result;
          end else begin
            state    <= RD_ISSUE;
            beat_q   <= beat_nxt;
            mem_en   <= 1'b1;
            mem_addr <= addr_nxt;
          end
        end
        DONE: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: per-request cycle-trace model checked every cycle,
// plus literal latency/data expectations and a byte-wide memory model.
module tb_dmem_access_ctrl;

  localparam int unsigned AW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_error;
  logic [31:0]   resp_rdata;
  logic          mem_en;
  logic          mem_read_write;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data_in;
  logic [7:0]    mem_data_out;

  dmem_access_ctrl #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
    .mem_en(mem_en), .mem_read_write(mem_read_write), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          ready;
    logic          rv;
    logic          re;
    logic [31:0]   rd;
    logic          en;
    logic          rw;
    logic [AW-1:0] addr;
    logic [31:0]   din;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  vec_t cur;
  vec_t exp_q[$];
  vec_t dut_v;
  logic [7:0] mem [0:8191];
  logic [7:0] ref_mem [0:8191];

  assign dut_v = {req_ready, resp_valid, resp_error, resp_rdata,
                  mem_en, mem_read_write, mem_addr, mem_data_in};

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-wide memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_read_write) mem[mem_addr] <= mem_data_in[7:0];
      else                mem_data_out  <= mem[mem_addr];
    end
  end

  // Build the full expected output trace of one accepted request.
  task automatic schedule(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [AW-1:0] a, input logic [31:0] wd);
    vec_t        v;
    int          n;
    logic [31:0] val;
    logic [AW-1:0] ak;
    bit          err;
    err = (sz == 2'd3) || (sz == 2'd2 && a[1:0] != 2'b00) || (sz == 2'd1 && a[0]);
    n   = 1 << sz;
    val = 32'd0;
    if (!err) begin
      for (int k = 0; k < n; k++) begin
        ak = a + AW'(k);
        v = '0;
        v.en = 1'b1;
        v.addr = ak;
        if (w) begin
          v.rw  = 1'b1;
          v.din = (wd >> (8 * k)) & 32'hFF;
          ref_mem[ak] = v.din[7:0];
          exp_q.push_back(v);
        end else begin
          val = val | (32'(ref_mem[ak]) << (8 * k));
          exp_q.push_back(v);
          exp_q.push_back(vec_t'(0));
        end
      end
      if (!w && sg && n < 4 && val[8*n-1]) val = val | ~((32'd1 << (8 * n)) - 32'd1);
    end
    v = '0;
    v.rv = 1'b1;
    v.re = err;
    v.rd = (err || w) ? 32'd0 : val;
    exp_q.push_back(v);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      cur = '0;
      chk_en = 1'b1;
    end else begin
      if (cur.ready && req_valid) schedule(req_write, req_size, req_signed, req_addr, req_wdata);
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else begin
        cur = '0;
        cur.ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (dut_v !== cur) begin
        errors++;
        $display("FAIL trace cyc=%0d got rdy=%b rv=%b re=%b rd=%h en=%b rw=%b a=%h d=%h want rdy=%b rv=%b re=%b rd=%h en=%b rw=%b a=%h d=%h",
                 cyc, req_ready, resp_valid, resp_error, resp_rdata, mem_en, mem_read_write,
                 mem_addr, mem_data_in, cur.ready, cur.rv, cur.re, cur.rd, cur.en, cur.rw,
                 cur.addr, cur.din);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wait_ready(output int c0);
    bit got;
    got = 1'b0;
    c0 = -1;
    for (int i = 0; i < 50 && !got; i++) begin
      if (req_ready) begin
        got = 1'b1;
        c0 = cyc;
      end else @(negedge clk);
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL ready_timeout got=0 want=1");
    end
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [AW-1:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er);
    int c0;
    bit got;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    wait_ready(c0);
    @(negedge clk);
    req_valid = 1'b0; req_write = ~w; req_size = ~sz; req_signed = ~sg;
    req_addr = ~a; req_wdata = ~wd;
    lat = -1; rd = 32'hDEAD_BEEF; er = 1'bx;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (resp_valid) begin
        got = 1'b1;
        lat = cyc - c0;
        rd = resp_rdata;
        er = resp_error;
      end else @(negedge clk);
    end
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  int          c0, c1;

  initial begin
    for (int i = 0; i < 8192; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    mem[13'h1FFF] = 8'h80;
    ref_mem[13'h1FFF] = 8'h80;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_outputs", 32'({resp_valid, resp_error, mem_en, mem_read_write}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Word store then word load of the same location.
    do_req(1'b1, 2'd2, 1'b0, 13'h0100, 32'h1122_3344, lat, rd, er);
    chk("wst_lat", 32'(lat), 32'd5);
    chk("wst_err", 32'(er), 32'd0);
    chk("wst_rdata", rd, 32'd0);
    chk("wst_mem", {mem[13'h103], mem[13'h102], mem[13'h101], mem[13'h100]}, 32'h1122_3344);
    do_req(1'b0, 2'd2, 1'b1, 13'h0100, 32'h0, lat, rd, er);
    chk("wld_lat", 32'(lat), 32'd9);
    chk("wld_rdata", rd, 32'h1122_3344);

    // Byte loads at the top address, signed and unsigned.
    do_req(1'b0, 2'd0, 1'b1, 13'h1FFF, 32'h0, lat, rd, er);
    chk("bld_s_lat", 32'(lat), 32'd3);
    chk("bld_s_rdata", rd, 32'hFFFF_FF80);
    do_req(1'b0, 2'd0, 1'b0, 13'h1FFF, 32'h0, lat, rd, er);
    chk("bld_u_rdata", rd, 32'h0000_0080);

    // Halfword store/load with sign extension.
    do_req(1'b1, 2'd1, 1'b0, 13'h0200, 32'hABCD_8765, lat, rd, er);
    chk("hst_lat", 32'(lat), 32'd3);
    do_req(1'b0, 2'd1, 1'b1, 13'h0200, 32'h0, lat, rd, er);
    chk("hld_lat", 32'(lat), 32'd5);
    chk("hld_rdata", rd, 32'hFFFF_8765);

    // Misaligned and illegal-size requests.
    do_req(1'b0, 2'd1, 1'b0, 13'h0101, 32'h0, lat, rd, er);
    chk("mis_h_lat", 32'(lat), 32'd1);
    chk("mis_h_err", 32'(er), 32'd1);
    chk("mis_h_rdata", rd, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 13'h0102, 32'h0, lat, rd, er);
    chk("mis_w_err", 32'(er), 32'd1);
    do_req(1'b1, 2'd3, 1'b0, 13'h0000, 32'h5555_5555, lat, rd, er);
    chk("size3_err", 32'(er), 32'd1);
    chk("size3_mem", 32'(mem[13'h0000]), 32'd0);

    // Reset in cycle 4 of a word load.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 13'h0100;
    wait_ready(c0);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_cycle", 32'(cyc - c0), 32'd4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_outputs", 32'({req_ready, resp_valid, mem_en, mem_addr}), 32'd0);
    @(negedge clk);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, 2'd0, 1'b0, 13'h0101, 32'h0, lat, rd, er);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_rdata", rd, 32'h0000_0033);

    // Back-to-back word stores with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 13'h0300; req_wdata = 32'hA1B2_C3D4;
    wait_ready(c0);
    @(negedge clk);
    req_addr = 13'h0304; req_wdata = 32'h0506_0708;
    wait_ready(c1);
    chk("b2b_spacing", 32'(c1 - c0), 32'd6);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("b2b_mem0", {mem[13'h303], mem[13'h302], mem[13'h301], mem[13'h300]}, 32'hA1B2_C3D4);
    chk("b2b_mem1", {mem[13'h307], mem[13'h306], mem[13'h305], mem[13'h304]}, 32'h0506_0708);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
